// File: rtl/axil_apb_pkg.sv
// axil_apb_pkg: shared FSM states, response codes and response helper for the AXI-lite to APB bridge
package axil_apb_pkg;
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RRESP,
    BRESP
  } state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/axil_apb_arb.sv
// axil_apb_arb: 2-way round-robin grant between read and write requests
//  clk, rst_n      clock, async active-low reset
//  rd_req, wr_req  eligible read / write requests
//  advance         a grant was taken this cycle; remember who was served
//  gnt_rd, gnt_wr  one-hot (or zero) grant
module axil_apb_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_req,
  input  logic wr_req,
  input  logic advance,
  output logic gnt_rd,
  output logic gnt_wr
);
  // Resets to "write served last" so the first conflict goes to the read.
  logic last_wr_q, last_wr_d;
  assign gnt_rd = rd_req & (~wr_req | last_wr_q);
  assign gnt_wr = wr_req & (~rd_req | ~last_wr_q);
  always_comb last_wr_d = advance ? gnt_wr : last_wr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_wr_q <= 1'b1;
    else        last_wr_q <= last_wr_d;
endmodule

// File: rtl/axil_apb_bridge.sv
// axil_apb_bridge: AXI-lite slave to APB4 master, one transaction at a time
//  clk, rst_n     clock, async active-low reset
//  s_axil_aw*/w*  write address/data (AW and W are accepted together)
//  s_axil_b*      write response
//  s_axil_ar*     read address
//  s_axil_r*      read data/response
//  m_apb_*        APB4 master (paddr word-aligned, pstrb zero on reads)
//  Optional: define APB_TIMEOUT_EN to build an ACCESS-phase watchdog of TIMEOUT_CYCLES
//  that aborts a hung transfer with SLVERR.
module axil_apb_bridge
  import axil_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_apb_paddr,
  output logic [2:0]            m_apb_pprot,
  output logic                  m_apb_psel,
  output logic                  m_apb_penable,
  output logic                  m_apb_pwrite,
  output logic [DATA_WIDTH-1:0] m_apb_pwdata,
  output logic [STRB_WIDTH-1:0] m_apb_pstrb,
  input  logic [DATA_WIDTH-1:0] m_apb_prdata,
  input  logic                  m_apb_pready,
  input  logic                  m_apb_pslverr
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  idle, gnt_rd, gnt_wr, acc_rd, acc_wr, timeout;
  assign idle = rst_n & (state_q == IDLE);
  axil_apb_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_req  (s_axil_arvalid),
    .wr_req  (s_axil_awvalid & s_axil_wvalid),
    .advance (acc_rd | acc_wr),
    .gnt_rd  (gnt_rd),
    .gnt_wr  (gnt_wr)
  );
  assign acc_rd         = idle & gnt_rd;
  assign acc_wr         = idle & gnt_wr;
  assign s_axil_arready = acc_rd;
  assign s_axil_awready = acc_wr;
  assign s_axil_wready  = acc_wr;
  assign s_axil_rvalid  = state_q == RRESP;
  assign s_axil_bvalid  = state_q == BRESP;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = resp_q;
  assign s_axil_bresp   = resp_q;
  // psel/penable decode straight from state so an async reset drops them at once.
  assign m_apb_psel     = (state_q == SETUP) | (state_q == ACCESS);
  assign m_apb_penable  = state_q == ACCESS;
  assign m_apb_paddr    = paddr_q;
  assign m_apb_pprot    = pprot_q;
  assign m_apb_pwrite   = pwrite_q;
  assign m_apb_pwdata   = pwdata_q;
  assign m_apb_pstrb    = pstrb_q;
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) > 0 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout = (state_q == ACCESS) & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_comb
    cnt_d = state_q == SETUP ? '0 :
            (state_q == ACCESS && !m_apb_pready) ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pprot_d  = pprot_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    resp_d   = resp_q;
    unique case (state_q)
      IDLE: begin
        if (acc_rd) begin
          state_d  = SETUP;
          paddr_d  = s_axil_araddr & ADDR_MASK;
          pprot_d  = s_axil_arprot;
          pwrite_d = 1'b0;
          pwdata_d = '0;
          pstrb_d  = '0;
        end else if (acc_wr) begin
          state_d  = SETUP;
          paddr_d  = s_axil_awaddr & ADDR_MASK;
          pprot_d  = s_axil_awprot;
          pwrite_d = 1'b1;
          pwdata_d = s_axil_wdata;
          pstrb_d  = s_axil_wstrb;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (m_apb_pready) begin
          state_d = pwrite_q ? BRESP : RRESP;
          resp_d  = resp_of(m_apb_pslverr);
          rdata_d = pwrite_q ? '0 : m_apb_prdata;
        end else if (timeout) begin
          state_d = pwrite_q ? BRESP : RRESP;
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
        end
      end
      RRESP: state_d = s_axil_rready ? IDLE : RRESP;
      BRESP: state_d = s_axil_bready ? IDLE : BRESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pprot_q  <= pprot_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
    end
endmodule

// File: tb/tb_axil_apb_bridge.sv
// tb_axil_apb_bridge: directed self-checking bench for axil_apb_bridge
module tb_axil_apb_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata, paddr, pwdata, prdata;
  logic [2:0]  awprot, arprot, pprot;
  logic [3:0]  wstrb, pstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        psel, penable, pwrite, pready, pslverr;
  int          pass = 0, total = 0;
  always #5 clk = ~clk;
  axil_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .m_apb_paddr(paddr), .m_apb_pprot(pprot), .m_apb_psel(psel), .m_apb_penable(penable),
    .m_apb_pwrite(pwrite), .m_apb_pwdata(pwdata), .m_apb_pstrb(pstrb),
    .m_apb_prdata(prdata), .m_apb_pready(pready), .m_apb_pslverr(pslverr)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    int ncyc;
    logic exp_rd;
    rst_n = 1'b0; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arprot = '0; rready = 0; prdata = '0; pready = 0; pslverr = 0;
    arvalid = 1'b1;
    tick(); tick();
    chk("rst_arready", arready, 0);
    chk("rst_psel", {psel, penable, rvalid, bvalid, awready}, 0);
    chk("rst_rdata", rdata, 0);
    arvalid = 0;
    rst_n = 1'b1;
    tick();
    // single read
    araddr = 32'h1000_0004; arprot = 3'b010; arvalid = 1; pready = 1; prdata = 32'hDEAD_BEEF;
    #1 chk("rd_arready@0", arready, 1);
    tick(); arvalid = 0;
    chk("rd_setup@1", {psel, penable, pwrite}, 3'b100);
    chk("rd_paddr", paddr, 32'h1000_0004);
    chk("rd_pprot_pstrb", {pprot, pstrb}, {3'b010, 4'h0});
    tick();
    chk("rd_access@2", {psel, penable}, 2'b11);
    tick();
    chk("rd_rvalid@3", {rvalid, psel, penable}, 3'b100);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd_rresp", rresp, 2'b00);
    rready = 1; tick(); rready = 0;
    chk("rd_done", rvalid, 0);
    // single write
    awaddr = 32'h1000_0008; awprot = 3'b001; wdata = 32'h1234_5678; wstrb = 4'h3;
    awvalid = 1; wvalid = 1;
    #1 chk("wr_ready", {awready, wready, arready}, 3'b110);
    tick(); awvalid = 0; wvalid = 0;
    chk("wr_setup", {psel, penable, pwrite}, 3'b101);
    chk("wr_paddr", paddr, 32'h1000_0008);
    chk("wr_pwdata", pwdata, 32'h1234_5678);
    chk("wr_pstrb", pstrb, 4'h3);
    tick();
    chk("wr_access", {psel, penable}, 2'b11);
    tick();
    chk("wr_bvalid", {bvalid, bresp, psel}, {1'b1, 2'b00, 1'b0});
    chk("wr_rdata_zero", rdata, 0);
    bready = 1; tick(); bready = 0;
    chk("wr_done", bvalid, 0);
    // conflicting requests: round-robin R,W,R,W...; unaligned addresses get aligned
    araddr = 32'h2000_0013; awaddr = 32'h3000_0021; wstrb = 4'hF;
    arvalid = 1; awvalid = 1; wvalid = 1; rready = 1; bready = 1; pready = 1;
    for (int i = 0; i < 8; i++) begin
      exp_rd = (i % 2) == 0;
      #1;
      chk($sformatf("rr%0d_grant", i), {arready, awready, wready, psel}, {exp_rd, !exp_rd, !exp_rd, 1'b0});
      tick();
      chk($sformatf("rr%0d_setup", i), {psel, pwrite}, {1'b1, !exp_rd});
      chk($sformatf("rr%0d_paddr", i), paddr, exp_rd ? 32'h2000_0010 : 32'h3000_0020);
      chk($sformatf("rr%0d_nogrant", i), {arready, awready}, 0);
      tick();
      chk($sformatf("rr%0d_access", i), penable, 1);
      tick();
      chk($sformatf("rr%0d_resp", i), {rvalid, bvalid, psel}, {exp_rd, !exp_rd, 1'b0});
      tick();
    end
    arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0;
    // slow slave with error
    araddr = 32'h4000_0000; arprot = 3'b100; arvalid = 1; pready = 0;
    #1 chk("slow_arready", arready, 1);
    tick(); arvalid = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("slow_hold%0d", k), {psel, penable, pwrite, pprot, pstrb}, {3'b110, 3'b100, 4'h0});
      chk($sformatf("slow_paddr%0d", k), paddr, 32'h4000_0000);
      tick();
    end
    pready = 1; pslverr = 1; prdata = 32'hCAFE_F00D;
    chk("slow_last_access", {psel, penable}, 2'b11);
    tick(); pready = 0; pslverr = 0;
    chk("slow_rresp", {rvalid, rresp, psel}, {1'b1, 2'b10, 1'b0});
    chk("slow_rdata", rdata, 32'hCAFE_F00D);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("slow_rvalid_hold%0d", k), {rvalid, rresp}, {1'b1, 2'b10});
    end
    rready = 1; tick(); rready = 0;
    chk("slow_done", rvalid, 0);
    // reset in ACCESS
    araddr = 32'h5000_0000; arvalid = 1; pready = 0;
    tick(); arvalid = 0;
    tick();
    chk("rst_mid_access", {psel, penable}, 2'b11);
    rst_n = 0;
    #1 chk("rst_mid_drop", {psel, penable, rvalid, bvalid}, 0);
    chk("rst_mid_rdata", rdata, 0);
    tick(); rst_n = 1; tick();
    chk("post_rst_idle", {psel, rvalid}, 0);
    araddr = 32'h5000_0004; arvalid = 1; pready = 1; prdata = 32'h0BAD_F00D;
    #1 chk("post_rst_arready", arready, 1);
    tick(); arvalid = 0; tick(); tick();
    chk("post_rst_resp", {rvalid, rresp}, {1'b1, 2'b00});
    chk("post_rst_rdata", rdata, 32'h0BAD_F00D);
    rready = 1; tick(); rready = 0;
    // hung slave
    araddr = 32'h6000_0000; arvalid = 1; pready = 0;
    tick(); arvalid = 0; tick();
`ifdef APB_TIMEOUT_EN
    ncyc = 0;
    for (int k = 0; k < 100 && !rvalid; k++) begin
      ncyc += int'(penable);
      tick();
    end
    chk("to_access_cycles", ncyc, 16);
    chk("to_resp", {rvalid, rresp, psel, penable}, {1'b1, 2'b10, 2'b00});
    chk("to_rdata", rdata, 0);
    rready = 1; tick(); rready = 0;
`else
    ncyc = 0;
    for (int k = 0; k < 1000; k++) begin
      ncyc += int'(rvalid);
      tick();
    end
    chk("noto_no_resp", ncyc, 0);
    chk("noto_still_access", {psel, penable}, 2'b11);
    rst_n = 0; tick(); rst_n = 1; tick();
`endif
    chk("end_idle", {psel, rvalid, bvalid}, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
